// File: rtl/bip_debug_unit_if.sv
// Byte-level handshake between the bip debug unit and the UART transmitter.
interface bip_debug_unit_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/bip_debug_unit.sv
// Gates the bip core, counts executed cycles until halt, then streams
// a 7-byte PC/ACC/count snapshot frame to the UART byte transmitter.
module bip_debug_unit #(
  parameter int          PC_W  = 11,
  parameter int          ACC_W = 16,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_halt,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [ACC_W-1:0]  i_acc,
  bip_debug_unit_if.master  tx,
  output logic              o_bip_en,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {IDLE, RUN, LOAD, WAIT, DONE} state_e;

  state_e      state_q;
  logic [15:0] cnt_q, pc_q, acc_q;
  logic [2:0]  idx_q;
  logic        bip_en_q, start_q, busy_q, done_q;
  logic [7:0]  data_q;

  logic [15:0] cnt_d;
  logic [2:0]  idx_d;
  logic [7:0]  byte_d;

  // cnt_q doubles as the count snapshot: it stops changing once RUN is left.
  always_comb begin
    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    idx_d  = idx_q + 3'd1;
    byte_d = HDR;
    case (idx_d)
      3'd1:    byte_d = pc_q[15:8];
      3'd2:    byte_d = pc_q[7:0];
      3'd3:    byte_d = acc_q[15:8];
      3'd4:    byte_d = acc_q[7:0];
      3'd5:    byte_d = cnt_q[15:8];
      3'd6:    byte_d = cnt_q[7:0];
      default: byte_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      bip_en_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bip_en_q <= 1'b1;
          state_q  <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (i_halt) begin
            pc_q     <= 16'(i_pc);
            acc_q    <= 16'(i_acc);
            bip_en_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            start_q  <= 1'b1;
            data_q   <= HDR;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx.tx_done) begin
            if (idx_q == 3'd6) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_d;
              data_q  <= byte_d;
              start_q <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_bip_en    = bip_en_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign tx.tx_start = start_q;
  assign tx.tx_data  = data_q;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed and randomized frames for bip_debug_unit, checked against a
// frame model built from halt cycle number, PC and ACC.
module tb_bip_debug_unit;
  localparam int PC_W  = 11;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_halt = 1'b0;
  logic [PC_W-1:0]  i_pc = '0;
  logic [ACC_W-1:0] i_acc = '0;
  logic             o_bip_en, o_busy, o_done;

  bip_debug_unit_if tx_if();

  bip_debug_unit #(.PC_W(PC_W), .ACC_W(ACC_W), .HDR(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_halt   (i_halt),
    .i_pc     (i_pc),
    .i_acc    (i_acc),
    .tx       (tx_if),
    .o_bip_en (o_bip_en),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    i_halt = 1'b0;
    tx_if.tx_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_bip_en", o_bip_en, 0);
    check("rst_start", tx_if.tx_start, 0);
    check("rst_data", tx_if.tx_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    reset = 1'b1;
  endtask

  task automatic run_frame(input int halt_at, input logic [10:0] pc, input logic [15:0] acc,
                           input int dly, input bit spur, input int abort_after);
    logic [7:0]  exp_b [7];
    logic [15:0] c;
    logic [7:0]  last;
    int runs, nbytes, ndone, cd;
    bit pending, aborted;

    c = (halt_at > 65535) ? 16'hFFFF : 16'(halt_at);
    exp_b[0] = 8'hA5;
    exp_b[1] = {5'b0, pc[10:8]};
    exp_b[2] = pc[7:0];
    exp_b[3] = acc[15:8];
    exp_b[4] = acc[7:0];
    exp_b[5] = c[15:8];
    exp_b[6] = c[7:0];

    reset_dut();
    i_pc  = pc;
    i_acc = acc;
    runs  = 0;
    @(negedge clk);
    check("first_run_en", o_bip_en, 1);
    for (int t = 0; t < halt_at + 5; t++) begin
      if (!o_bip_en) break;
      runs++;
      i_halt = (runs >= halt_at);
      tx_if.tx_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("run_cycles", runs, halt_at);
    i_pc  = PC_W'($urandom);
    i_acc = ACC_W'($urandom);

    nbytes = 0; ndone = 0; cd = 0; pending = 0; aborted = 0; last = '0;
    for (int t = 0; t < 7 * (dly + 3) + 20; t++) begin
      tx_if.tx_done = 1'b0;
      if (!pending && nbytes == 7 && o_done) break;
      if (tx_if.tx_start) begin
        check("no_double_start", pending, 0);
        check("busy_in_frame", o_busy, 1);
        if (nbytes < 7) check($sformatf("byte%0d", nbytes), tx_if.tx_data, exp_b[nbytes]);
        nbytes++;
        pending = 1;
        cd = dly;
        last = tx_if.tx_data;
        if (spur) tx_if.tx_done = 1'b1;
      end else if (pending) begin
        if (tx_if.tx_data !== last) check("data_held", tx_if.tx_data, last);
        cd--;
        if (cd <= 0) begin
          tx_if.tx_done = 1'b1;
          pending = 0;
          ndone++;
          if (abort_after > 0 && ndone == abort_after) begin
            @(negedge clk);
            tx_if.tx_done = 1'b0;
            aborted = 1;
            break;
          end
        end
      end
      @(negedge clk);
    end

    if (aborted) begin
      check("bytes_before_abort", nbytes, abort_after);
      return;
    end
    check("byte_count", nbytes, 7);
    check("end_done", o_done, 1);
    check("end_busy", o_busy, 0);
    check("end_bip_en", o_bip_en, 0);

    i_halt = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tx_if.tx_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (tx_if.tx_start) check("start_in_done", tx_if.tx_start, 0);
      if (!o_done) check("done_sticky", o_done, 1);
    end
    tx_if.tx_done = 1'b0;
    check("done_final", o_done, 1);
  endtask

  initial begin
    tx_if.tx_done = 1'b0;
    @(negedge clk);
    run_frame(10, 11'h005, 16'h1234, 1, 0, 0);
    run_frame(1, 11'h000, 16'hFFFF, 1, 0, 0);
    run_frame(20, 11'h7A3, 16'h00C1, 50, 0, 0);
    run_frame(70000, 11'h123, 16'hBEEF, 1, 0, 0);
    run_frame(15, 11'h0F0, 16'h5A5A, 2, 0, 3);
    run_frame(7, 11'h456, 16'h8001, 1, 0, 0);
    run_frame(12, 11'h3C3, 16'h7E81, 3, 1, 0);
    for (int k = 0; k < 3; k++) begin
      run_frame(int'($urandom_range(1, 300)), 11'($urandom), 16'($urandom),
                int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
